// File: rtl/reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_queue
// Purpose  : Write-side front end of the 32x32 register file. Accepts
//            writeback requests (ALU results / memory loads), applies load
//            formatting, buffers them in a DEPTH-entry FIFO and drains one
//            entry per cycle onto the register file write port. Also exposes
//            a per-register pending scoreboard for read stalls.
// Ports    : clk, rst (async, active-low)
//            req_*        : writeback request handshake and payload
//            wb_hold      : inhibit draining this cycle
//            rf_we/rd/data: register file write port (head of queue)
//            rs1/rs2      : read addresses; rsN_pending scoreboard outputs
//            count        : occupied FIFO entries
//            rsN_fwd_*    : optional forwarding of youngest queued value
// Config   : define REG_WB_FORWARD_EN to enable forwarding; otherwise the
//            forward outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_queue #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [4:0]                 req_rd,
    input  logic [31:0]                req_data,
    input  logic                       req_is_load,
    input  logic [2:0]                 req_funct3,
    input  logic [1:0]                 req_addr_lo,
    input  logic                       wb_hold,
    output logic                       rf_we,
    output logic [4:0]                 rf_rd,
    output logic [31:0]                rf_data,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    output logic                       rs1_pending,
    output logic                       rs2_pending,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       rs1_fwd_valid,
    output logic                       rs2_fwd_valid,
    output logic [31:0]                rs1_fwd_data,
    output logic [31:0]                rs2_fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [4:0]    rd_mem_d   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          full, empty, accept, push, pop;
    logic [31:0]   fmt_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full;
    assign accept    = req_valid && req_ready;
    // rd==0 completes the handshake but is discarded (x0 is never written).
    assign push      = accept && (req_rd != 5'd0);
    assign pop       = !empty && !wb_hold && rst;

    assign rf_we   = pop;
    assign rf_rd   = empty ? 5'd0  : rd_mem_q[rd_ptr_q];
    assign rf_data = empty ? 32'd0 : data_mem_q[rd_ptr_q];
    assign count   = count_q;

    // Load formatting: byte/halfword select then sign/zero extension.
    always_comb begin
        ld_byte  = 8'd0;
        ld_half  = req_addr_lo[1] ? req_data[31:16] : req_data[15:0];
        fmt_data = req_data;
        case (req_addr_lo)
            2'd0:    ld_byte = req_data[7:0];
            2'd1:    ld_byte = req_data[15:8];
            2'd2:    ld_byte = req_data[23:16];
            default: ld_byte = req_data[31:24];
        endcase
        if (req_is_load) begin
            case (req_funct3)
                3'b000:  fmt_data = {{24{ld_byte[7]}}, ld_byte};
                3'b100:  fmt_data = {24'd0, ld_byte};
                3'b001:  fmt_data = {{16{ld_half[15]}}, ld_half};
                3'b101:  fmt_data = {16'd0, ld_half};
                default: fmt_data = req_data;
            endcase
        end
    end

    // FIFO next-state. Push and pop never target the same slot: equal
    // pointers imply empty (no pop) or full (no push).
    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        valid_d    = valid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            rd_mem_d[wr_ptr_q]   = req_rd;
            data_mem_d[wr_ptr_q] = fmt_data;
            valid_d[wr_ptr_q]    = 1'b1;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Pending scoreboard: queued entries plus the request landing this edge.
    always_comb begin
        rs1_pending = push && (req_rd == rs1);
        rs2_pending = push && (req_rd == rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (rd_mem_q[i] == rs1)) rs1_pending = 1'b1;
            if (valid_q[i] && (rd_mem_q[i] == rs2)) rs2_pending = 1'b1;
        end
        if (rs1 == 5'd0) rs1_pending = 1'b0;
        if (rs2 == 5'd0) rs2_pending = 1'b0;
    end

`ifdef REG_WB_FORWARD_EN
    logic [PW-1:0] fwd_idx;

    // Walk from oldest to youngest so the last match wins.
    always_comb begin
        rs1_fwd_valid = 1'b0;
        rs2_fwd_valid = 1'b0;
        rs1_fwd_data  = 32'd0;
        rs2_fwd_data  = 32'd0;
        fwd_idx       = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PW'(k);
            if (valid_q[fwd_idx] && (rs1 != 5'd0) && (rd_mem_q[fwd_idx] == rs1)) begin
                rs1_fwd_valid = 1'b1;
                rs1_fwd_data  = data_mem_q[fwd_idx];
            end
            if (valid_q[fwd_idx] && (rs2 != 5'd0) && (rd_mem_q[fwd_idx] == rs2)) begin
                rs2_fwd_valid = 1'b1;
                rs2_fwd_data  = data_mem_q[fwd_idx];
            end
        end
    end
`else
    assign rs1_fwd_valid = 1'b0;
    assign rs2_fwd_valid = 1'b0;
    assign rs1_fwd_data  = 32'd0;
    assign rs2_fwd_data  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_queue
// Purpose  : Directed self-checking bench for reg_writeback_queue (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [4:0]  req_rd;
    logic [31:0] req_data;
    logic        req_is_load;
    logic [2:0]  req_funct3;
    logic [1:0]  req_addr_lo;
    logic        wb_hold;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [4:0]  rs1, rs2;
    logic        rs1_pending, rs2_pending;
    logic [1:0]  count;
    logic        rs1_fwd_valid, rs2_fwd_valid;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;

    int checks = 0;
    int errors = 0;

    reg_writeback_queue #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_data(req_data), .req_is_load(req_is_load), .req_funct3(req_funct3),
        .req_addr_lo(req_addr_lo), .wb_hold(wb_hold),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .rs1(rs1), .rs2(rs2), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .count(count),
        .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
        .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic ld, input logic [2:0] f3, input logic [1:0] a);
        req_valid   = v;
        req_rd      = rd;
        req_data    = d;
        req_is_load = ld;
        req_funct3  = f3;
        req_addr_lo = a;
    endtask

    // Enqueue one load of 0x80FF7F01 into an empty queue and check the
    // formatted value on the write port the following cycle.
    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [1:0] a, input logic [31:0] exp);
        drive(1'b1, 5'd4, 32'h80FF_7F01, 1'b1, f3, a);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
        #1;
        chk({tag, "_we"}, {31'd0, rf_we}, 32'd1);
        chk(tag, rf_data, exp);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        wb_hold = 1'b0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);

        // Reset state
        repeat (2) tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_we",    {31'd0, rf_we},     32'd0);
        chk("rst_rd",    {27'd0, rf_rd},     32'd0);
        chk("rst_data",  rf_data,            32'd0);
        chk("rst_count", {30'd0, count},     32'd0);
        chk("rst_fwd",   {31'd0, rs1_fwd_valid | rs2_fwd_valid}, 32'd0);
        #3 rst = 1'b1;
        tick();

        // Basic ALU writeback, 1-cycle latency
        rs1 = 5'd5;
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
        #1;
        chk("alu_ready",   {31'd0, req_ready},   32'd1);
        chk("alu_pend_in", {31'd0, rs1_pending}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
        #1;
        chk("alu_we",    {31'd0, rf_we}, 32'd1);
        chk("alu_rd",    {27'd0, rf_rd}, 32'd5);
        chk("alu_data",  rf_data,        32'h1234_5678);
        chk("alu_count", {30'd0, count}, 32'd1);
        tick();
        chk("alu_count0", {30'd0, count}, 32'd0);
        chk("alu_we0",    {31'd0, rf_we}, 32'd0);
        rs1 = 5'd0;

        // Load formatting
        load_chk("lb3",  3'b000, 2'd3, 32'hFFFF_FF80);
        load_chk("lbu1", 3'b100, 2'd1, 32'h0000_007F);
        load_chk("lh2",  3'b001, 2'd2, 32'hFFFF_80FF);
        load_chk("lhu0", 3'b101, 2'd0, 32'h0000_7F01);
        load_chk("lh3",  3'b001, 2'd3, 32'hFFFF_80FF);
        load_chk("lw",   3'b010, 2'd2, 32'h80FF_7F01);

        // Fill under hold, stall third request, then drain in order
        wb_hold = 1'b1;
        drive(1'b1, 5'd1, 32'h0000_0011, 1'b0, 3'd0, 2'd0);
        tick();
        drive(1'b1, 5'd2, 32'h0000_0022, 1'b0, 3'd0, 2'd0);
        tick();
        drive(1'b1, 5'd3, 32'h0000_0033, 1'b0, 3'd0, 2'd0);
        rs1 = 5'd2;
        #1;
        chk("full_count", {30'd0, count},     32'd2);
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        chk("full_pend",  {31'd0, rs1_pending}, 32'd1);
        tick();
        chk("stall_count", {30'd0, count}, 32'd2);
        chk("hold_we",     {31'd0, rf_we}, 32'd0);
        chk("hold_rd",     {27'd0, rf_rd}, 32'd1);
        chk("hold_data",   rf_data,        32'h0000_0011);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
        wb_hold = 1'b0;
        #1;
        chk("drain1_we", {31'd0, rf_we}, 32'd1);
        chk("drain1_rd", {27'd0, rf_rd}, 32'd1);
        tick();
        chk("drain2_we",   {31'd0, rf_we}, 32'd1);
        chk("drain2_rd",   {27'd0, rf_rd}, 32'd2);
        chk("drain2_data", rf_data,        32'h0000_0022);
        chk("drain2_cnt",  {30'd0, count}, 32'd1);
        tick();
        chk("drain_cnt0",  {30'd0, count}, 32'd0);
        chk("drain_pend0", {31'd0, rs1_pending}, 32'd0);

        // rd=0 request: accepted but discarded
        rs1 = 5'd0;
        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0);
        #1;
        chk("x0_ready", {31'd0, req_ready},   32'd1);
        chk("x0_pend",  {31'd0, rs1_pending}, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
        #1;
        chk("x0_count", {30'd0, count}, 32'd0);
        chk("x0_we",    {31'd0, rf_we}, 32'd0);

        // Same register queued twice: pending and youngest forward
        wb_hold = 1'b1;
        drive(1'b1, 5'd7, 32'h0000_000A, 1'b0, 3'd0, 2'd0);
        tick();
        drive(1'b1, 5'd7, 32'h0000_000B, 1'b0, 3'd0, 2'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
        rs1 = 5'd7;
        rs2 = 5'd0;
        #1;
        chk("dup_pend1", {31'd0, rs1_pending}, 32'd1);
        chk("dup_pend2", {31'd0, rs2_pending}, 32'd0);
`ifdef REG_WB_FORWARD_EN
        chk("dup_fwdv1", {31'd0, rs1_fwd_valid}, 32'd1);
        chk("dup_fwdd1", rs1_fwd_data,           32'h0000_000B);
`else
        chk("dup_fwdv1", {31'd0, rs1_fwd_valid}, 32'd0);
        chk("dup_fwdd1", rs1_fwd_data,           32'd0);
`endif
        chk("dup_fwdv2", {31'd0, rs2_fwd_valid}, 32'd0);

        // Full with a draining head: no pass-through; then concurrent push/pop
        wb_hold = 1'b0;
        drive(1'b1, 5'd9, 32'h0000_0099, 1'b0, 3'd0, 2'd0);
        #1;
        chk("nopass_ready", {31'd0, req_ready}, 32'd0);
        chk("nopass_we",    {31'd0, rf_we},     32'd1);
        tick();
        chk("pp_count_pre", {30'd0, count},     32'd1);
        chk("pp_ready",     {31'd0, req_ready}, 32'd1);
        chk("pp_head",      rf_data,            32'h0000_000B);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
        #1;
        chk("pp_count", {30'd0, count}, 32'd1);
        chk("pp_rd",    {27'd0, rf_rd}, 32'd9);
        chk("pp_data",  rf_data,        32'h0000_0099);
        tick();
        chk("pp_empty", {30'd0, count}, 32'd0);

        // Asynchronous reset with two entries queued
        wb_hold = 1'b1;
        drive(1'b1, 5'd10, 32'h0000_00AA, 1'b0, 3'd0, 2'd0);
        tick();
        drive(1'b1, 5'd11, 32'h0000_00BB, 1'b0, 3'd0, 2'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
        wb_hold = 1'b0;
        rs1 = 5'd10;
        #1 rst = 1'b0;
        #1;
        chk("arst_we",    {31'd0, rf_we},       32'd0);
        chk("arst_count", {30'd0, count},       32'd0);
        chk("arst_ready", {31'd0, req_ready},   32'd1);
        chk("arst_pend",  {31'd0, rs1_pending}, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_we",    {31'd0, rf_we}, 32'd0);
            chk("post_rst_count", {30'd0, count}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
